// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests and exception redirect in,
// hold/bubble/flush controls and stall statistics out.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [STAGES-1:0] stallreq;
  logic              excp_req;
  logic [ADDR_W-1:0] excp_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_timeout;

  modport master (
    output stallreq, excp_req, excp_pc,
    input  stall, bubble, flush, new_pc, stall_cnt, stall_timeout
  );

  modport slave (
    input  stallreq, excp_req, excp_pc,
    output stall, bubble, flush, new_pc, stall_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stage stall requests into hold/bubble vectors,
// sequences exception flushes, and tracks stall statistics with a watchdog.
//
// state | meaning
// IDLE  | normal operation, stalls honoured, exceptions accepted
// FLUSH | one-cycle flush with redirect; stalls and new exceptions suppressed
module pipe_ctrl #(
  parameter int STAGES     = 6,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 255
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_LIMIT);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state;
  logic                flush_q;
  logic [ADDR_W-1:0]   new_pc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WD_W-1:0]     wd_q;
  logic                timeout_q;

  logic [STAGES-1:0]   stall_v;
  logic [STAGES-1:0]   bubble_v;
  logic                hit;
  int                  k;
  logic                stall_any;
  logic                unused_ok;

  // PC and WB positions never originate a hold.
  assign unused_ok = ^{bus.stallreq[0], bus.stallreq[STAGES-1]};

  always_comb begin
    hit      = 1'b0;
    k        = 0;
    stall_v  = '0;
    bubble_v = '0;
    for (int i = 1; i < STAGES - 1; i++) begin
      if (bus.stallreq[i]) begin
        hit = 1'b1;
        k   = i;
      end
    end
    // Everything up to the deepest requester holds; the stage behind it gets the bubble.
    if (hit && !rst && !flush_q) begin
      for (int j = 0; j < STAGES; j++) begin
        stall_v[j]  = (j <= k);
        bubble_v[j] = (j == k + 1);
      end
    end
  end

  assign stall_any = |stall_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.excp_req) begin
            state    <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= bus.excp_pc;
          end
        end
        FLUSH: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
      endcase

      if (stall_any) begin
        if (cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
        if (wd_q != WD_LIM)
          wd_q <= wd_q + WD_W'(1);
        if (wd_q == WD_LIM - WD_W'(1))
          timeout_q <= 1'b1;
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign bus.stall         = stall_v;
  assign bus.bubble        = bubble_v;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_cnt     = cnt_q;
  assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and small counter/watchdog) share
// one directed stimulus and are compared against a behavioural model each cycle.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sr;
  logic        ex;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pipe_ctrl_if #(.STAGES(6), .ADDR_W(32), .CNT_W(16)) if_a ();
  pipe_ctrl_if #(.STAGES(6), .ADDR_W(32), .CNT_W(3))  if_b ();

  assign if_a.stallreq = sr;
  assign if_a.excp_req = ex;
  assign if_a.excp_pc  = pc;
  assign if_b.stallreq = sr;
  assign if_b.excp_req = ex;
  assign if_b.excp_pc  = pc;

  pipe_ctrl #(.STAGES(6), .ADDR_W(32), .CNT_W(16), .WDOG_LIMIT(255)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a));
  pipe_ctrl #(.STAGES(6), .ADDR_W(32), .CNT_W(3), .WDOG_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_cnt_a, m_cnt_b, m_wd_a, m_wd_b;
  bit          m_to_a, m_to_b;

  function automatic int deepest(input logic [5:0] req);
    logic [5:0] m;
    m = req & 6'b011110;
    for (int i = 5; i >= 0; i--)
      if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] exp_stall(input logic r, input bit f, input logic [5:0] req);
    int d;
    d = deepest(req);
    if (r || f || d < 0) return 6'd0;
    return 6'((1 << (d + 1)) - 1);
  endfunction

  function automatic logic [5:0] exp_bubble(input logic r, input bit f, input logic [5:0] req);
    int d;
    d = deepest(req);
    if (r || f || d < 0) return 6'd0;
    return 6'(1 << (d + 1));
  endfunction

  always @(posedge clk) begin
    logic [5:0] s;
    s = exp_stall(rst, m_flush, sr);
    if (rst) begin
      m_flush = 0; m_pc = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_wd_a = 0; m_wd_b = 0;
      m_to_a = 0; m_to_b = 0;
    end else begin
      if (s != 0) begin
        m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
        m_cnt_b = (m_cnt_b < 7) ? m_cnt_b + 1 : 7;
        m_wd_a++; m_wd_b++;
        if (m_wd_a == 255) m_to_a = 1;
        if (m_wd_b == 4)   m_to_b = 1;
      end else begin
        m_wd_a = 0; m_wd_b = 0;
      end
      if (!m_flush && ex) begin
        m_flush = 1;
        m_pc    = pc;
      end else begin
        m_flush = 0;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_a",   if_a.stall,  exp_stall(rst, m_flush, sr));
      chk("bubble_a",  if_a.bubble, exp_bubble(rst, m_flush, sr));
      chk("stall_b",   if_b.stall,  exp_stall(rst, m_flush, sr));
      chk("bubble_b",  if_b.bubble, exp_bubble(rst, m_flush, sr));
      chk("flush_a",   if_a.flush,  m_flush);
      chk("flush_b",   if_b.flush,  m_flush);
      chk("new_pc_a",  if_a.new_pc, m_pc);
      chk("new_pc_b",  if_b.new_pc, m_pc);
      chk("cnt_a",     if_a.stall_cnt, 64'(m_cnt_a));
      chk("cnt_b",     if_b.stall_cnt, 64'(m_cnt_b));
      chk("timeout_a", if_a.stall_timeout, m_to_a);
      chk("timeout_b", if_b.stall_timeout, m_to_b);
    end
  end

  task automatic drive(input logic r, input logic [5:0] s, input logic e, input logic [31:0] p);
    @(posedge clk);
    #2;
    rst = r; sr = s; ex = e; pc = p;
  endtask

  initial begin
    rst = 1'b1; sr = 6'b111110; ex = 1'b0; pc = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("lit_rst_stall",  if_a.stall, 6'd0);
    chk("lit_rst_bubble", if_a.bubble, 6'd0);
    chk("lit_rst_flush",  if_a.flush, 1'b0);
    chk("lit_rst_pc",     if_a.new_pc, 32'd0);
    chk("lit_rst_cnt",    if_a.stall_cnt, 16'd0);
    chk("lit_rst_to",     if_a.stall_timeout, 1'b0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    repeat (10) drive(1'b0, 6'd0, 1'b0, 32'd0);

    drive(1'b0, 6'b000100, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_lu_stall",  if_a.stall,  6'b000111);
    chk("lit_lu_bubble", if_a.bubble, 6'b001000);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_lu_cnt", if_a.stall_cnt, 16'd1);

    drive(1'b0, 6'b001100, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_ex_stall",  if_a.stall,  6'b001111);
    chk("lit_ex_bubble", if_a.bubble, 6'b010000);
    drive(1'b0, 6'b100000, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wb_stall", if_a.stall, 6'd0);

    drive(1'b0, 6'd0, 1'b1, 32'hBFC00380);
    drive(1'b0, 6'b000100, 1'b1, 32'h12345678);
    @(negedge clk);
    chk("lit_fl_flush", if_a.flush, 1'b1);
    chk("lit_fl_pc",    if_a.new_pc, 32'hBFC00380);
    chk("lit_fl_stall", if_a.stall, 6'd0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_fl_drop",  if_a.flush, 1'b0);
    chk("lit_fl_hold",  if_a.new_pc, 32'hBFC00380);

    drive(1'b0, 6'd0, 1'b1, 32'hA0000000);
    drive(1'b0, 6'd0, 1'b1, 32'hA0000004);
    @(negedge clk);
    chk("lit_b2b_flush1", if_a.flush, 1'b1);
    drive(1'b0, 6'd0, 1'b1, 32'hA0000008);
    @(negedge clk);
    chk("lit_b2b_drop", if_a.flush, 1'b0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_b2b_flush2", if_a.flush, 1'b1);
    chk("lit_b2b_pc",     if_a.new_pc, 32'hA0000008);

    drive(1'b0, 6'b001000, 1'b1, 32'h80000180);
    @(negedge clk);
    chk("lit_co_stall", if_a.stall, 6'b001111);
    chk("lit_co_flush", if_a.flush, 1'b0);
    drive(1'b0, 6'b001000, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_co_flush1", if_a.flush, 1'b1);
    chk("lit_co_pc",     if_a.new_pc, 32'h80000180);
    chk("lit_co_nostall", if_a.stall, 6'd0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);

    drive(1'b0, 6'd0, 1'b1, 32'hBFC00000);
    drive(1'b1, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_rf_flush", if_a.flush, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_rf_after", if_a.flush, 1'b0);
    chk("lit_rf_pc",    if_a.new_pc, 32'd0);

    repeat (4) drive(1'b0, 6'b001000, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wd_pre", if_b.stall_timeout, 1'b0);
    drive(1'b0, 6'b001000, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wd_set", if_b.stall_timeout, 1'b1);
    drive(1'b0, 6'b001000, 1'b0, 32'd0);
    repeat (2) drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wd_sticky", if_b.stall_timeout, 1'b1);
    chk("lit_wd_a",      if_a.stall_timeout, 1'b0);
    drive(1'b1, 6'd0, 1'b0, 32'd0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wd_rst",  if_b.stall_timeout, 1'b0);
    chk("lit_cnt_rst", if_b.stall_cnt, 3'd0);

    repeat (10) drive(1'b0, 6'b001000, 1'b0, 32'd0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_sat_b", if_b.stall_cnt, 3'd7);
    chk("lit_cnt_a", if_a.stall_cnt, 16'd10);
    repeat (2) drive(1'b0, 6'b010000, 1'b0, 32'd0);
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_sat_hold", if_b.stall_cnt, 3'd7);
    chk("lit_cnt_a12",  if_a.stall_cnt, 16'd12);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
